// File: rtl/ex_stage_ctrl.sv
// Execute-stage controller: decodes RV32I ALU/branch/memory encodings into ALU
// control codes, holds operands in an EX register and captures results downstream.
module ex_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_br_taken,
  output logic [31:0] out_br_target,
  output logic        out_illegal,
  output logic [31:0] out_count
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]  dec_ctrl_s;
  logic        dec_illegal_s;
  logic        dec_beq_s;
  logic        dec_bne_s;
  logic        dec_use_imm_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic [31:0] dec_target_s;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_a_q;
  logic [31:0] ex_b_q;
  logic [3:0]  ex_ctrl_q;
  logic        ex_beq_q;
  logic        ex_bne_q;
  logic        ex_illegal_q;
  logic [31:0] ex_target_q;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q;
  logic        out_br_taken_q;
  logic [31:0] out_br_target_q;
  logic        out_illegal_q;
  logic [31:0] out_count_q, out_count_d;

  logic        advance_s;
  logic        accept_s;
  logic        load_out_s;
  logic        br_taken_s;

  // Instruction decode; unsupported encodings become a no-op with zero operands.
  always_comb begin
    dec_ctrl_s    = ALU_NOP;
    dec_illegal_s = 1'b0;
    dec_beq_s     = 1'b0;
    dec_bne_s     = 1'b0;
    dec_use_imm_s = 1'b0;
    case (in_opcode)
      OP_R: begin
        case (in_funct3)
          3'b000:  dec_ctrl_s = in_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  dec_ctrl_s = ALU_AND;
          3'b110:  dec_ctrl_s = ALU_OR;
          default: dec_illegal_s = 1'b1;
        endcase
      end
      OP_I: begin
        dec_use_imm_s = 1'b1;
        case (in_funct3)
          3'b000:  dec_ctrl_s = ALU_ADD;
          3'b111:  dec_ctrl_s = ALU_AND;
          3'b110:  dec_ctrl_s = ALU_OR;
          default: dec_illegal_s = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        dec_use_imm_s = 1'b1;
        dec_ctrl_s    = ALU_ADD;
      end
      OP_BRANCH: begin
        case (in_funct3)
          3'b000: begin
            dec_ctrl_s = ALU_SUB;
            dec_beq_s  = 1'b1;
          end
          3'b001: begin
            dec_ctrl_s = ALU_SUB;
            dec_bne_s  = 1'b1;
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      default: dec_illegal_s = 1'b1;
    endcase
    if (dec_illegal_s) begin
      dec_ctrl_s = ALU_NOP;
      dec_a_s    = 32'd0;
      dec_b_s    = 32'd0;
    end else begin
      dec_a_s = in_rs1;
      dec_b_s = dec_use_imm_s ? in_imm : in_rs2;
    end
  end

  // Branch target uses its own adder so the shared ALU stays free for the compare.
  assign dec_target_s = in_pc + in_imm;

  assign advance_s  = ~out_valid_q | out_ready;
  assign in_ready   = ~ex_valid_q | advance_s;
  assign accept_s   = in_valid & in_ready & ~flush;
  assign load_out_s = advance_s & ex_valid_q & ~flush;
  assign br_taken_s = (ex_beq_q & alu_zero) | (ex_bne_q & ~alu_zero);

  // Next-state for valid bits and the handshake counter (counter ignores flush).
  always_comb begin
    ex_valid_d  = ex_valid_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    if (flush) begin
      ex_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (in_ready) begin
        ex_valid_d = in_valid;
      end else begin
        ex_valid_d = ex_valid_q;
      end
      if (advance_s) begin
        out_valid_d = ex_valid_q;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
    if (out_valid_q & out_ready) begin
      out_count_d = out_count_q + 32'd1;
    end else begin
      out_count_d = out_count_q;
    end
  end

  // EX pipeline register; operands only change on accept so the ALU sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_a_q       <= 32'd0;
      ex_b_q       <= 32'd0;
      ex_ctrl_q    <= ALU_ADD;
      ex_beq_q     <= 1'b0;
      ex_bne_q     <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_target_q  <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept_s) begin
        ex_a_q       <= dec_a_s;
        ex_b_q       <= dec_b_s;
        ex_ctrl_q    <= dec_ctrl_s;
        ex_beq_q     <= dec_beq_s;
        ex_bne_q     <= dec_bne_s;
        ex_illegal_q <= dec_illegal_s;
        ex_target_q  <= dec_target_s;
      end
    end
  end

  // Output register capturing the ALU result and branch resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_result_q    <= 32'd0;
      out_br_taken_q  <= 1'b0;
      out_br_target_q <= 32'd0;
      out_illegal_q   <= 1'b0;
      out_count_q     <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      if (load_out_s) begin
        out_result_q    <= alu_result;
        out_br_taken_q  <= br_taken_s;
        out_br_target_q <= ex_target_q;
        out_illegal_q   <= ex_illegal_q;
      end
    end
  end

  assign alu_a         = ex_a_q;
  assign alu_b         = ex_b_q;
  assign alu_ctrl      = ex_ctrl_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_br_taken  = out_br_taken_q;
  assign out_br_target = out_br_target_q;
  assign out_illegal   = out_illegal_q;
  assign out_count     = out_count_q;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed bench for ex_stage_ctrl with a behavioural 4-op ALU feeding alu_result/alu_zero.
module tb_ex_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_br_taken;
  logic [31:0] out_br_target;
  logic        out_illegal;
  logic [31:0] out_count;

  int checks;
  int failures;

  ex_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target), .out_illegal(out_illegal),
    .out_count(out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared ALU stand-in
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    in_valid    = 1'b1;
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7_5 = f75;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_pc       = pc;
  endtask

  // Accept one instruction, check EX control, then check the captured output.
  task automatic run_one(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f75, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] e_ctrl, input logic [31:0] e_res,
                         input logic e_br, input logic [31:0] e_tgt, input logic e_ill);
    offer(opc, f3, f75, rs1, rs2, imm, pc);
    tick();
    in_valid = 1'b0;
    chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e_ctrl});
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, out_result, e_res);
    chk({tag, "_br"}, {31'd0, out_br_taken}, {31'd0, e_br});
    chk({tag, "_target"}, out_br_target, e_tgt);
    chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    offer(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_out_count", out_count, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD: result two edges after accept, then handshake counted
    run_one("add", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0,
            4'b0000, 32'd12, 1'b0, 32'd0, 1'b0);
    tick();
    chk("add_count", out_count, 32'd1);
    chk("add_drain", {31'd0, out_valid}, 32'd0);

    run_one("sub", 7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0,
            4'b0001, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    run_one("beq", 7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100,
            4'b0001, 32'd0, 1'b1, 32'h120, 1'b0);
    run_one("bne", 7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100,
            4'b0001, 32'd0, 1'b0, 32'h120, 1'b0);
    tick();
    chk("chain_count", out_count, 32'd4);

    // Backpressure: three ADDIs with out_ready low for four edges
    out_ready = 1'b0;
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0);
    tick();
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd2, 32'd0);
    tick();
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd3, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_res", out_result, 32'd1);
    tick();
    tick();
    chk("bp_hold_res2", out_result, 32'd1);
    chk("bp_hold_b", alu_b, 32'd2);
    chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_res2", out_result, 32'd2);
    chk("bp_count5", out_count, 32'd5);
    tick();
    chk("bp_res3", out_result, 32'd3);
    chk("bp_valid3", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_count7", out_count, 32'd7);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with a simultaneous offer; no output handshake on the flush edge
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd10, 32'd0);
    tick();
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd20, 32'd0);
    tick();
    offer(7'b0010011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd30, 32'd0);
    flush = 1'b1;
    out_ready = 1'b0;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_count", out_count, 32'd7);
    tick();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);
    tick();
    chk("fl_dropped2", {31'd0, out_valid}, 32'd0);
    chk("fl_count2", out_count, 32'd7);

    // Illegal encodings, then legal OR/AND clear the flag
    run_one("ill_lui", 7'b0110111, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0,
            4'b1111, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("ill_alu_a", alu_a, 32'd0);
    run_one("ill_f3", 7'b0110011, 3'b100, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0,
            4'b1111, 32'd0, 1'b0, 32'd0, 1'b1);
    run_one("or", 7'b0110011, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0,
            4'b0011, 32'hFF, 1'b0, 32'd0, 1'b0);
    run_one("andi", 7'b0010011, 3'b111, 1'b0, 32'hFF, 32'd0, 32'h0F, 32'd0,
            4'b0010, 32'h0F, 1'b0, 32'h0F, 1'b0);
    run_one("load", 7'b0000011, 3'b010, 1'b0, 32'h1000, 32'd0, 32'h8, 32'h40,
            4'b0000, 32'h1008, 1'b0, 32'h48, 1'b0);
    tick();
    chk("ill_count", out_count, 32'd12);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    offer(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd4);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_result", out_result, 32'd0);
    chk("mr_count", out_count, 32'd0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_target", out_br_target, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
# ex_stage_ctrl

Execute-stage controller that drives the shared 4-op ALU (ADD/SUB/AND/OR) and consumes its result and zero flag. It decodes RV32I opcode/funct fields into ALU control codes, registers operands in an EX pipeline register, and captures the ALU result, branch decision and branch target into an output register. Valid/ready handshakes sit on both ends, plus a synchronous flush. It sits between decode and the memory stage.

## Interface
- Parameters: none (data width fixed at 32).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; kills EX and output contents
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  block can accept this cycle
- in_opcode  in  7  instruction[6:0]
- in_funct3  in  3  instruction[14:12]
- in_funct7_5  in  1  instruction[30]
- in_rs1, in_rs2, in_imm, in_pc  in  32 each  operands, sign-extended immediate, PC
- alu_a, alu_b  out  32 each  ALU operands (from EX register)
- alu_ctrl  out  4  ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 1111 no-op (ALU outputs 0)
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  output register holds a result
- out_ready  in  1  memory stage accepts
- out_result  out  32  captured alu_result
- out_br_taken  out  1  branch resolved taken
- out_br_target  out  32  in_pc + in_imm
- out_illegal  out  1  unsupported encoding
- out_count  out  32  completed output handshakes

## Operation
- Decode, combinational on inputs, registered at accept:
  - 0110011 R-type: f3=000 with f7_5=0 gives ADD, with f7_5=1 gives SUB. f3=111 gives AND. f3=110 gives OR. Operands rs1/rs2.
  - 0010011 I-type: f3=000 ADD, 111 AND, 110 OR. Operands rs1/imm.
  - 0000011 load, 0100011 store: ADD, operands rs1/imm.
  - 1100011 branch: f3=000 BEQ and f3=001 BNE both use SUB, operands rs1/rs2.
  - Anything else: illegal. alu_ctrl=1111, operands 0, illegal flag set, instruction still flows down the pipe.
- EX register holds ex_valid, alu_a, alu_b, alu_ctrl, is_beq, is_bne, illegal, target.
  - target = in_pc + in_imm, computed modulo 2^32 with a dedicated adder, not the ALU.
- Output capture: out_result = alu_result.
  - out_br_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero).
  - out_br_taken is 0 for non-branches and for illegal encodings.
- out_count increments on each out_valid & out_ready cycle. Wraps from 0xFFFFFFFF to 0. Not cleared by flush.

## Timing
- Reset (async assert, sync deassert by system): ex_valid=0, out_valid=0, alu_a=alu_b=0, alu_ctrl=0000, out_result=0, out_br_taken=0, out_br_target=0, out_illegal=0, out_count=0. in_ready=1 after reset.
- advance = ~out_valid | out_ready. in_ready = ~ex_valid | advance, combinational.
- Accept at edge k (in_valid & in_ready): EX loads; ALU evaluates during cycle k+1.
- Edge k+1: if advance, the output register loads EX contents and out_valid=ex_valid.
- Latency 2 edges from accept to out_valid. Throughput 1 instruction per cycle with out_ready held high.
- Backpressure: while out_valid & ~out_ready, the output register and EX register hold. alu_a/alu_b/alu_ctrl stay stable.
- Simultaneous output handshake and EX advance in one edge is legal; no bubble is inserted.
- flush=1 at an edge: ex_valid and out_valid go to 0.
  - Flush wins over a simultaneous accept; the offered instruction is dropped.
  - A simultaneous out_valid&out_ready handshake still counts in out_count.
  - Data registers may keep stale values.
- Reset mid-operation discards all in-flight instructions immediately.

## Test plan
- ADD x: rs1=5, rs2=7, R-type f3=000 f7_5=0, out_ready=1 -> alu_ctrl=0000 one cycle after accept; out_result=12, out_valid 2 edges after accept, out_count=1.
- SUB wrap: rs1=0, rs2=1, f7_5=1 -> out_result=0xFFFFFFFF, br_taken=0. Then BEQ rs1=rs2=9, pc=0x100, imm=0x20 -> br_taken=1, target=0x120. BNE with the same operands -> br_taken=0.
- Backpressure: stream 3 ADDIs (imm 1,2,3 on rs1=0) with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts and outputs hold at 1. After release, results arrive as 1,2,3 with none lost or duplicated.
- Flush: accept 2 instructions, assert flush for 1 cycle together with a new in_valid -> out_valid=0 next cycle, new instruction dropped, out_count unchanged.
- Illegal: opcode 0110111 -> alu_ctrl=1111, out_illegal=1, out_result=0, br_taken=0. Then f3=100 R-type -> illegal as well.
- Reset mid-flight: assert rst_n=0 while out_valid=1 -> all outputs return to reset values asynchronously, without waiting for a clock edge.
